bin2bcd_display: RTL and testbench
==================================

# bin2bcd_display

Sequential signed binary-to-packed-BCD converter feeding the six-digit seven-segment display block. It takes a signed fixed-point value in thousandths and produces the 24-bit packed BCD word `n` plus `sign`. The digit layout is Hundreds, Tens, Ones, Tenths, Hundredths, Thousandths, most significant nibble first, so 123.456 appears as 24'h123456. It also emits the display's reserved codes 24'hFFFFFF (overflow) and 24'hFFFFFE (error). Conversion is iterative double-dabble at one input bit per clock; results are held stable between conversions.

## Interface
- IN_W, 32: width of signed input `value`. Legal range 21..32.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request conversion; sampled only when `busy`=0.
- value  input  IN_W  signed two's-complement value in thousandths; sampled with `start`.
- err  input  1  upstream error flag; sampled with `start`.
- n  output  24  packed BCD result or reserved code; registered.
- sign  output  1  1 = negative numeric result; registered.
- busy  output  1  multi-cycle conversion in progress.
- done  output  1  one-cycle pulse when `n`/`sign` have just been updated.

## Operation
- States: IDLE, CONV.
- IDLE, `start`=1, `err`=1: `n`<=24'hFFFFFE, `sign`<=0, `done` pulses, stay IDLE. `err` has priority over overflow.
- IDLE, `start`=1, `err`=0:
  - mag = |value|, computed in IN_W bits unsigned. The most negative value yields 2^(IN_W-1).
  - neg = value[IN_W-1].
  - mag > 999999: `n`<=24'hFFFFFF, `sign`<=0, `done` pulses, stay IDLE.
  - otherwise: load shift register {24'h0, mag}, latch neg, bit counter <= 0, go to CONV.
- CONV, each cycle:
  - every BCD nibble >= 5 gets +3.
  - then the whole {bcd, bin} register shifts left by 1.
  - counter increments.
- On the IN_W-th shift: `n` <= resulting BCD, `sign` <= neg, `done` pulses, return to IDLE.
- A zero result forces `sign`=0 (no negative zero).
- `start` while `busy`=1 is ignored and not queued. `value` and `err` may change freely during CONV.
- `n` and `sign` change only on a `done` cycle or on reset.
- Only nibble values 0..9 and the two reserved words ever appear on `n`.

## Timing
- Reset (any state, including mid-CONV): state IDLE, `n`=24'h000000, `sign`=0, `busy`=0, `done`=0. A conversion in progress is discarded.
- Fast paths (err, overflow): `start` sampled at edge k; `n`/`sign` valid and `done`=1 in the cycle after edge k; `busy` stays 0.
- Numeric path: `start` sampled at edge k; `busy`=1 from after edge k through edge k+IN_W; `n`/`sign` updated and `done`=1 in the cycle after edge k+IN_W, with `busy`=0 in that cycle. Latency is IN_W cycles (32 by default).
- A new `start` is accepted in the same cycle `done` is high. Back-to-back conversion throughput is IN_W+1 cycles.

## Test plan
- value=123456, start -> after 32 cycles `done`=1, `n`=24'h123456, `sign`=0; `busy` high for exactly 32 cycles.
- value=-1500 -> `n`=24'h001500, `sign`=1. value=0 -> `n`=24'h000000, `sign`=0. value=999999 -> `n`=24'h999999.
- value=1000000 -> next cycle `n`=24'hFFFFFF, `sign`=0, `done`=1, `busy` never asserted. value=-2^31 -> same response.
- err=1 with value=5 -> next cycle `n`=24'hFFFFFE, `sign`=0. err=1 with value=2000000 -> also 24'hFFFFFE (err wins).
- Start with 42; pulse start with 777 at cycle 10 -> second request ignored, result 24'h000042. Start then accepted in the `done` cycle converts correctly.
- Start conversion of -654321; assert reset at cycle 15 -> `n`=0, `sign`=0, `busy`=0, no `done`. A fresh start then yields `n`=24'h654321, `sign`=1.

Source files
------------

// File: rtl/bin2bcd_display.sv
// bin2bcd_display
//
// Sequential signed binary-to-packed-BCD converter for the six-digit
// seven-segment display. The input is a signed value in thousandths. The
// result is a 24-bit packed BCD word laid out as Hundreds, Tens, Ones,
// Tenths, Hundredths, Thousandths, most significant nibble first.
// Two reserved words are used: 24'hFFFFFF means overflow and 24'hFFFFFE
// means error. A numeric conversion uses double-dabble and takes IN_W
// clocks, one input bit per clock.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset
//   start  - conversion request, sampled only while busy is low
//   value  - signed two's-complement input in thousandths
//   err    - upstream error flag, sampled together with start
//   n      - registered packed BCD result or reserved code
//   sign   - registered sign, 1 = negative non-zero result
//   busy   - high while a multi-cycle conversion is running
//   done   - one-cycle pulse when n/sign have just been updated

module bin2bcd_display #(
    parameter int IN_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IN_W-1:0] value,
    input  logic            err,
    output logic [23:0]     n,
    output logic            sign,
    output logic            busy,
    output logic            done
);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    localparam logic [IN_W-1:0] MAX_MAG  = IN_W'(999999);
    localparam logic [5:0]      LAST_CNT = 6'(IN_W - 1);

    state_t             state, state_next;
    logic [IN_W+23:0]   sr, sr_next;
    logic [5:0]         cnt, cnt_next;
    logic               neg, neg_next;
    logic [23:0]        n_next;
    logic               sign_next;
    logic               done_next;

    logic [IN_W-1:0]    mag;
    logic [23:0]        bcd_adj;
    logic [IN_W+23:0]   shifted;

    // Magnitude of the input. The two's-complement negate is done in IN_W
    // unsigned bits, so the most negative value becomes 2^(IN_W-1), which
    // is always above 999999 and therefore lands on the overflow path.
    always_comb begin
        mag = value[IN_W-1] ? (~value + 1'b1) : value;
    end

    // One double-dabble step: every BCD nibble of 5 or more gets +3, then
    // the whole {bcd, bin} register shifts left by one.
    always_comb begin
        bcd_adj = sr[IN_W +: 24];
        for (int i = 0; i < 6; i++) begin
            if (sr[IN_W + 4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = sr[IN_W + 4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj[22:0], sr[IN_W-1:0], 1'b0};
    end

    // Next-state and output logic. Each register holds its value unless a
    // transition below updates it. done is low by default, so it can only
    // pulse for one cycle.
    always_comb begin
        state_next = state;
        sr_next    = sr;
        cnt_next   = cnt;
        neg_next   = neg;
        n_next     = n;
        sign_next  = sign;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (err) begin
                        n_next    = 24'hFFFFFE;
                        sign_next = 1'b0;
                        done_next = 1'b1;
                    end else if (mag > MAX_MAG) begin
                        n_next    = 24'hFFFFFF;
                        sign_next = 1'b0;
                        done_next = 1'b1;
                    end else begin
                        sr_next    = {24'h000000, mag};
                        neg_next   = value[IN_W-1];
                        cnt_next   = 6'd0;
                        state_next = CONV;
                    end
                end
            end

            CONV: begin
                sr_next  = shifted;
                cnt_next = cnt + 6'd1;
                if (cnt == LAST_CNT) begin
                    n_next     = shifted[IN_W +: 24];
                    // A zero result never shows as negative zero.
                    sign_next  = neg && (shifted[IN_W +: 24] != 24'h000000);
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset discards any conversion that is
    // in progress and clears the visible result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= 6'd0;
            neg   <= 1'b0;
            n     <= 24'h000000;
            sign  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            sr    <= sr_next;
            cnt   <= cnt_next;
            neg   <= neg_next;
            n     <= n_next;
            sign  <= sign_next;
            done  <= done_next;
        end
    end

    assign busy = (state == CONV);

endmodule

// File: tb/tb_bin2bcd_display.sv
// tb_bin2bcd_display
//
// Self-checking bench for bin2bcd_display with IN_W = 32. The expected
// values come from a reference model that works directly on decimal
// digits, using plain arithmetic.

module tb_bin2bcd_display;

    localparam int IN_W = 32;

    logic            clk;
    logic            reset;
    logic            start;
    logic [IN_W-1:0] value;
    logic            err;
    logic [23:0]     n;
    logic            sign;
    logic            busy;
    logic            done;

    int tests;
    int fails;

    bin2bcd_display #(.IN_W(IN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .value (value),
        .err   (err),
        .n     (n),
        .sign  (sign),
        .busy  (busy),
        .done  (done)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference display word. Reserved codes are chosen first. Otherwise
    // the six decimal digits of the magnitude are packed into nibbles.
    function automatic logic [23:0] modelN(input logic [31:0] v, input logic e);
        longint m;
        logic [23:0] r;
        m = longint'($signed(v));
        if (m < 0) m = -m;
        if (e) return 24'hFFFFFE;
        if (m > 999999) return 24'hFFFFFF;
        r = 24'h0;
        for (int i = 0; i < 6; i++) begin
            r = r | (24'(m % 10) << (4 * i));
            m = m / 10;
        end
        return r;
    endfunction

    // Reference sign: set only for a negative, non-reserved, non-zero result.
    function automatic logic modelSign(input logic [31:0] v, input logic e);
        longint m;
        m = longint'($signed(v));
        if (e) return 1'b0;
        if (m >= 0) return 1'b0;
        if (-m > 999999) return 1'b0;
        return 1'b1;
    endfunction

    // Expected number of busy cycles: zero on the fast paths, IN_W otherwise.
    function automatic int modelBusy(input logic [31:0] v, input logic e);
        longint m;
        m = longint'($signed(v));
        if (m < 0) m = -m;
        if (e || m > 999999) return 0;
        return IN_W;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Present one start request. It is called at posedge+1 and returns at
    // posedge+1, just after the edge that sampled start.
    task automatic applyStimulus(input logic [31:0] v, input logic e);
        value = v;
        err   = e;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting busy cycles, then check the result.
    task automatic waitAndCheck(input string tag, input logic [23:0] expN,
                                input logic expSign, input int expBusy);
        int busyCycles;
        int waited;
        busyCycles = 0;
        waited = 0;
        while (done !== 1'b1 && waited < 60) begin
            if (busy === 1'b1) busyCycles++;
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput({tag, " done"}, 32'(done), 32'd1);
        checkOutput({tag, " n"}, 32'(n), 32'(expN));
        checkOutput({tag, " sign"}, 32'(sign), 32'(expSign));
        checkOutput({tag, " busy in done cycle"}, 32'(busy), 32'd0);
        checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'(expBusy));
    endtask

    task automatic runConversion(input string tag, input logic [31:0] v, input logic e);
        applyStimulus(v, e);
        waitAndCheck(tag, modelN(v, e), modelSign(v, e), modelBusy(v, e));
    endtask

    initial begin
        logic [23:0] heldN;
        logic        heldSign;
        logic [31:0] rv;
        logic        re;
        int          doneSeen;

        tests = 0;
        fails = 0;
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        err   = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset n", 32'(n), 32'h0);
        checkOutput("reset sign", 32'(sign), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        @(posedge clk);
        #1;

        // Directed numeric cases.
        runConversion("pos 123456", 32'd123456, 1'b0);
        runConversion("neg -1500", -32'sd1500, 1'b0);
        runConversion("zero", 32'd0, 1'b0);
        runConversion("max 999999", 32'd999999, 1'b0);
        runConversion("min -999999", -32'sd999999, 1'b0);

        // done is a single-cycle pulse and the result holds while inputs move.
        heldN = n;
        heldSign = sign;
        @(posedge clk);
        #1;
        checkOutput("done pulse clears", 32'(done), 32'd0);
        value = 32'd5;
        err = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold n", 32'(n), 32'(heldN));
        checkOutput("hold sign", 32'(sign), 32'(heldSign));

        // Overflow and error fast paths.
        runConversion("ovf 1000000", 32'd1000000, 1'b0);
        runConversion("ovf -2^31", 32'h80000000, 1'b0);
        runConversion("ovf -1000000", -32'sd1000000, 1'b0);
        runConversion("err 5", 32'd5, 1'b1);
        runConversion("err beats ovf", 32'd2000000, 1'b1);

        // A start during CONV is ignored, and value/err may change freely.
        applyStimulus(32'd42, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        applyStimulus(32'd777, 1'b1);
        value = 32'd123;
        waitAndCheck("ignored start", 24'h000042, 1'b0, IN_W - 10);

        // A start accepted in the done cycle converts normally.
        runConversion("start in done cycle", -32'sd7, 1'b0);

        // Reset in the middle of a conversion discards it.
        applyStimulus(-32'sd654321, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("mid reset n", 32'(n), 32'h0);
        checkOutput("mid reset sign", 32'(sign), 32'd0);
        checkOutput("mid reset busy", 32'(busy), 32'd0);
        checkOutput("mid reset done", 32'(done), 32'd0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
        end
        checkOutput("no activity after reset", 32'(doneSeen), 32'd0);
        runConversion("after reset -654321", -32'sd654321, 1'b0);

        // Randomized requests against the model: mostly in range, with
        // some full-width values and occasional error requests.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: rv = $urandom;
                1: rv = -32'($urandom_range(0, 1200000));
                default: rv = 32'($urandom_range(0, 1200000));
            endcase
            re = ($urandom_range(0, 7) == 0);
            runConversion("random", rv, re);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
